// File: rtl/timer_bank.sv
// Bank of NCH down-counting timers sharing one prescaler, with sticky per-channel interrupts.
// Optional macro TIMER_BANK_READBACK_EN adds a registered counter/pending readback port.
module timer_bank #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned PRESC = 1,
    localparam int unsigned CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [CHW-1:0]   cfg_ch,
    input  logic             cfg_sel,
    input  logic [WIDTH-1:0] cfg_wdata,
    input  logic [NCH-1:0]   int_ack,
`ifdef TIMER_BANK_READBACK_EN
    input  logic [CHW-1:0]   rd_ch,
    output logic [WIDTH-1:0] rd_count,
    output logic [NCH-1:0]   rd_pending,
`endif
    output logic [NCH-1:0]   int_out
);

    localparam int unsigned PW = (PRESC > 1) ? $clog2(PRESC) : 1;

    logic [PW-1:0]    presc_q, presc_d;
    logic             tick;

    logic [WIDTH-1:0] cnt_q    [NCH];
    logic [WIDTH-1:0] cnt_d    [NCH];
    logic [WIDTH-1:0] period_q [NCH];
    logic [WIDTH-1:0] period_d [NCH];
    logic [NCH-1:0]   en_q, en_d, per_q, per_d, irq_q, irq_d, pend_q, pend_d, int_q, int_d;
    logic [NCH-1:0]   ctrl_wr, period_wr, fire;

    always_comb begin
        tick    = (presc_q == PW'(PRESC - 1));
        presc_d = tick ? '0 : presc_q + PW'(1);
    end

    // Out-of-range cfg_ch never matches any channel index, so such writes fall through.
    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            ctrl_wr[i]   = cfg_we && !cfg_sel && (cfg_ch == CHW'(i));
            period_wr[i] = cfg_we && cfg_sel && (cfg_ch == CHW'(i));
            fire[i]      = tick && en_q[i] && !ctrl_wr[i] && (cnt_q[i] == WIDTH'(1));
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            cnt_d[i]    = cnt_q[i];
            period_d[i] = period_q[i];
            en_d[i]     = en_q[i];
            per_d[i]    = per_q[i];
            irq_d[i]    = irq_q[i];
            pend_d[i]   = pend_q[i];

            if (period_wr[i]) begin
                period_d[i] = cfg_wdata;
            end

            // A CTRL write swallows any tick landing on the same edge.
            if (ctrl_wr[i]) begin
                per_d[i] = cfg_wdata[1];
                irq_d[i] = cfg_wdata[2];
                if (!cfg_wdata[0]) begin
                    en_d[i]  = 1'b0;
                    cnt_d[i] = '0;
                end else if (!en_q[i]) begin
                    en_d[i]  = 1'b1;
                    cnt_d[i] = period_q[i];
                end
            end else if (tick && en_q[i]) begin
                if (fire[i]) begin
                    if (per_q[i]) begin
                        cnt_d[i] = period_q[i];
                    end else begin
                        cnt_d[i] = '0;
                        en_d[i]  = 1'b0;
                    end
                end else if (cnt_q[i] > WIDTH'(1)) begin
                    cnt_d[i] = cnt_q[i] - WIDTH'(1);
                end
            end

            // Fire wins over a simultaneous ack so no event is lost.
            if (fire[i]) begin
                pend_d[i] = 1'b1;
            end else if (int_ack[i]) begin
                pend_d[i] = 1'b0;
            end
        end
        int_d = pend_d & irq_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
            en_q    <= '0;
            per_q   <= '0;
            irq_q   <= '0;
            pend_q  <= '0;
            int_q   <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                cnt_q[i]    <= '0;
                period_q[i] <= '0;
            end
        end else begin
            presc_q  <= presc_d;
            en_q     <= en_d;
            per_q    <= per_d;
            irq_q    <= irq_d;
            pend_q   <= pend_d;
            int_q    <= int_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
        end
    end

    assign int_out = int_q;

`ifdef TIMER_BANK_READBACK_EN
    logic [WIDTH-1:0] rd_count_q, rd_count_d;
    logic [NCH-1:0]   rd_pending_q;

    always_comb begin
        rd_count_d = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (rd_ch == CHW'(i)) begin
                rd_count_d = cnt_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_count_q   <= '0;
            rd_pending_q <= '0;
        end else begin
            rd_count_q   <= rd_count_d;
            rd_pending_q <= pend_q;
        end
    end

    assign rd_count   = rd_count_q;
    assign rd_pending = rd_pending_q;
`endif

endmodule

// File: tb/tb_timer_bank.sv
// Self-checking bench for timer_bank: a PRESC=1 four-channel instance and a PRESC=4
// three-channel instance, driven from a vector table plus hand-written sequences.
module tb_timer_bank;

    typedef struct {
        logic        we;
        logic [1:0]  ch;
        logic        sel;
        logic [15:0] wd;
        logic [3:0]  ack;
        logic [3:0]  exp_int;
        logic [15:0] exp_rd;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        cfg_we, cfg_sel;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_wdata;
    logic [3:0]  int_ack, int_out;

    logic        c4_we, c4_sel;
    logic [1:0]  c4_ch;
    logic [15:0] c4_wdata;
    logic [2:0]  c4_ack, int4;

`ifdef TIMER_BANK_READBACK_EN
    logic [1:0]  rd_ch, rd_ch4;
    logic [15:0] rd_count, rd_count4;
    logic [3:0]  rd_pending;
    logic [2:0]  rd_pending4;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    logic [3:0]  exp_q  [$];
    logic [2:0]  exp4_q [$];
    logic [15:0] rd_q   [$];
    vec_t        tbl    [23];

    timer_bank #(.NCH(4), .WIDTH(16), .PRESC(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_sel   (cfg_sel),
        .cfg_wdata (cfg_wdata),
        .int_ack   (int_ack),
`ifdef TIMER_BANK_READBACK_EN
        .rd_ch     (rd_ch),
        .rd_count  (rd_count),
        .rd_pending(rd_pending),
`endif
        .int_out   (int_out)
    );

    timer_bank #(.NCH(3), .WIDTH(16), .PRESC(4)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .cfg_we    (c4_we),
        .cfg_ch    (c4_ch),
        .cfg_sel   (c4_sel),
        .cfg_wdata (c4_wdata),
        .int_ack   (c4_ack),
`ifdef TIMER_BANK_READBACK_EN
        .rd_ch     (rd_ch4),
        .rd_count  (rd_count4),
        .rd_pending(rd_pending4),
`endif
        .int_out   (int4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] ch, input logic sel,
                                input logic [15:0] wd, input logic [3:0] ack,
                                input logic [3:0] ei, input logic [15:0] er);
        vec_t v;
        v.we = we; v.ch = ch; v.sel = sel; v.wd = wd; v.ack = ack;
        v.exp_int = ei; v.exp_rd = er;
        return v;
    endfunction

    // One clock on the PRESC=1 instance; expected int_out queued, popped after the edge.
    task automatic cyc(input logic we, input logic [1:0] ch, input logic sel,
                       input logic [15:0] wd, input logic [3:0] ack,
                       input logic [3:0] exp_int, input string name);
        logic [3:0] e;
        cfg_we = we; cfg_ch = ch; cfg_sel = sel; cfg_wdata = wd; int_ack = ack;
        exp_q.push_back(exp_int);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk(name, {28'd0, int_out}, {28'd0, e});
        cfg_we = 1'b0; int_ack = '0;
    endtask

    task automatic cyc4(input logic we, input logic [1:0] ch, input logic sel,
                        input logic [15:0] wd, input logic [2:0] ack,
                        input logic [2:0] exp_int, input string name);
        logic [2:0] e;
        c4_we = we; c4_ch = ch; c4_sel = sel; c4_wdata = wd; c4_ack = ack;
        exp4_q.push_back(exp_int);
        @(posedge clk);
        #1;
        e = exp4_q.pop_front();
        chk(name, {29'd0, int4}, {29'd0, e});
        c4_we = 1'b0; c4_ack = '0;
    endtask

    initial begin
        int waited;
        logic [15:0] er;

        reset = 1'b1;
        cfg_we = 1'b0; cfg_ch = '0; cfg_sel = 1'b0; cfg_wdata = '0; int_ack = '0;
        c4_we = 1'b0; c4_ch = '0; c4_sel = 1'b0; c4_wdata = '0; c4_ack = '0;
`ifdef TIMER_BANK_READBACK_EN
        rd_ch = 2'd0; rd_ch4 = 2'd0;
`endif
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_int", {28'd0, int_out}, 32'd0);
        chk("reset_int4", {29'd0, int4}, 32'd0);
        reset = 1'b1;

        // ch0 periodic P=3, acks, then a PERIOD=7 write mid-run and a disable keeping pending.
        tbl[0]  = mk(1, 0, 1, 16'd3, 4'h0, 4'h0, 16'd0);
        tbl[1]  = mk(1, 0, 0, 16'd7, 4'h0, 4'h0, 16'd0);
        tbl[2]  = mk(0, 0, 0, 16'd0, 4'h0, 4'h0, 16'd3);
        tbl[3]  = mk(0, 0, 0, 16'd0, 4'h0, 4'h0, 16'd2);
        tbl[4]  = mk(0, 0, 0, 16'd0, 4'h0, 4'h1, 16'd1);
        tbl[5]  = mk(0, 0, 0, 16'd0, 4'h0, 4'h1, 16'd3);
        tbl[6]  = mk(0, 0, 0, 16'd0, 4'h1, 4'h0, 16'd2);
        tbl[7]  = mk(0, 0, 0, 16'd0, 4'h0, 4'h1, 16'd1);
        tbl[8]  = mk(0, 0, 0, 16'd0, 4'h1, 4'h0, 16'd3);
        tbl[9]  = mk(1, 0, 1, 16'd7, 4'h0, 4'h0, 16'd2);
        tbl[10] = mk(0, 0, 0, 16'd0, 4'h0, 4'h1, 16'd1);
        tbl[11] = mk(0, 0, 0, 16'd0, 4'h1, 4'h0, 16'd7);
        tbl[12] = mk(0, 0, 0, 16'd0, 4'h0, 4'h0, 16'd6);
        tbl[13] = mk(0, 0, 0, 16'd0, 4'h0, 4'h0, 16'd5);
        tbl[14] = mk(0, 0, 0, 16'd0, 4'h0, 4'h0, 16'd4);
        tbl[15] = mk(0, 0, 0, 16'd0, 4'h0, 4'h0, 16'd3);
        tbl[16] = mk(0, 0, 0, 16'd0, 4'h0, 4'h0, 16'd2);
        tbl[17] = mk(0, 0, 0, 16'd0, 4'h0, 4'h1, 16'd1);
        tbl[18] = mk(1, 0, 0, 16'd4, 4'h0, 4'h1, 16'd7);
        tbl[19] = mk(0, 0, 0, 16'd0, 4'h1, 4'h0, 16'd0);
        tbl[20] = mk(0, 0, 0, 16'd0, 4'h0, 4'h0, 16'd0);
        tbl[21] = mk(0, 0, 0, 16'd0, 4'h0, 4'h0, 16'd0);
        tbl[22] = mk(0, 0, 0, 16'd0, 4'h0, 4'h0, 16'd0);

        for (int i = 0; i < 23; i++) begin
            rd_q.push_back(tbl[i].exp_rd);
            cyc(tbl[i].we, tbl[i].ch, tbl[i].sel, tbl[i].wd, tbl[i].ack, tbl[i].exp_int,
                $sformatf("tbl%0d_int", i));
            er = rd_q.pop_front();
`ifdef TIMER_BANK_READBACK_EN
            chk($sformatf("tbl%0d_rd_count", i), {16'd0, rd_count}, {16'd0, er});
`endif
        end

        // ch3 with PERIOD=0 must never fire.
        cyc(1, 3, 1, 16'd0, 4'h0, 4'h0, "p0_per");
        cyc(1, 3, 0, 16'd7, 4'h0, 4'h0, "p0_en");
        for (int i = 0; i < 50; i++) cyc(0, 0, 0, 16'd0, 4'h0, 4'h0, "p0_nofire");
        cyc(1, 3, 0, 16'd0, 4'h0, 4'h0, "p0_dis");

        // ch1 one-shot P=5: single fire, then silence.
        cyc(1, 1, 1, 16'd5, 4'h0, 4'h0, "os_per");
        cyc(1, 1, 0, 16'd5, 4'h0, 4'h0, "os_en");
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 16'd0, 4'h0, 4'h0, "os_wait");
        cyc(0, 0, 0, 16'd0, 4'h0, 4'h2, "os_fire");
        cyc(0, 0, 0, 16'd0, 4'h2, 4'h0, "os_ack");
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 16'd0, 4'h0, 4'h0, "os_no_refire");

        // PRESC=4 instance: out-of-range channel writes, then ch2 periodic P=2.
        cyc4(1, 3, 1, 16'd1, 3'b000, 3'b000, "p4_bad_ch_per");
        cyc4(1, 3, 0, 16'd7, 3'b000, 3'b000, "p4_bad_ch_ctrl");
        cyc4(1, 2, 1, 16'd2, 3'b000, 3'b000, "p4_per");
        cyc4(1, 2, 0, 16'd7, 3'b000, 3'b000, "p4_en");
        waited = 0;
        while (int4 == 3'b000 && waited < 40) begin
            @(posedge clk);
            #1;
            waited++;
        end
        chk("p4_first_fire", {29'd0, int4}, 32'd4);
        cyc4(0, 0, 0, 16'd0, 3'b100, 3'b000, "p4_ack");
        for (int i = 2; i < 8; i++) cyc4(0, 0, 0, 16'd0, 3'b000, 3'b000, "p4_gap1");
        cyc4(0, 0, 0, 16'd0, 3'b100, 3'b100, "p4_ack_on_fire");
        cyc4(0, 0, 0, 16'd0, 3'b000, 3'b100, "p4_pend_kept");
        cyc4(0, 0, 0, 16'd0, 3'b100, 3'b000, "p4_ack2");
        for (int i = 11; i < 16; i++) cyc4(0, 0, 0, 16'd0, 3'b000, 3'b000, "p4_gap2");
        cyc4(0, 0, 0, 16'd0, 3'b000, 3'b100, "p4_third_fire");

        // All four channels periodic P=2, irq masking on ch0, then async reset mid-count.
        for (int i = 0; i < 4; i++) cyc(1, 2'(i), 1, 16'd2, 4'h0, 4'h0, "all_per");
        cyc(1, 0, 0, 16'd7, 4'h0, 4'h0, "all_en0");
        cyc(1, 1, 0, 16'd7, 4'h0, 4'h0, "all_en1");
        cyc(1, 2, 0, 16'd7, 4'h0, 4'h1, "all_en2");
        cyc(1, 3, 0, 16'd7, 4'h0, 4'h3, "all_en3");
        cyc(0, 0, 0, 16'd0, 4'h0, 4'h7, "all_fire2");
        cyc(0, 0, 0, 16'd0, 4'h0, 4'hf, "all_fire3");
        cyc(1, 0, 0, 16'd3, 4'h0, 4'he, "mask_ch0");
        cyc(1, 0, 0, 16'd7, 4'h0, 4'hf, "unmask_ch0");

        #2 reset = 1'b0;
        #1;
        chk("rst_async_int", {28'd0, int_out}, 32'd0);
        chk("rst_async_int4", {29'd0, int4}, 32'd0);
`ifdef TIMER_BANK_READBACK_EN
        chk("rst_rd", {rd_pending4, rd_pending, rd_count4, rd_count}, 32'd0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            chk("post_rst_quiet", {25'd0, int4, int_out}, 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/timer_bank.md
TIMER_BANK -- requirements
Module: timer_bank

Interface
REQ-001 Parameter: NCH, default 4, number of independent timer channels (1..8).
REQ-002 Parameter: WIDTH, default 16, counter and period width in bits (8..32).
REQ-003 Parameter: PRESC, default 1, clk cycles per tick (1..256).
REQ-004 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-low reset.
REQ-006 Port: cfg_we  input  1  config write strobe, sampled on clk rising edge.
REQ-007 Port: cfg_ch  input  $clog2(NCH) (min 1)  target channel of write.
REQ-008 Port: cfg_sel  input  1  register select: 0 = CTRL, 1 = PERIOD.
REQ-009 Port: cfg_wdata  input  WIDTH  write data. CTRL uses bit0 = enable, bit1 = periodic (0 = one-shot), bit2 = irq_en.
REQ-010 Port: int_ack  input  NCH  per-channel pending-clear pulse.
REQ-011 Port: int_out  output  NCH  per-channel interrupt = pending AND irq_en, registered.

Function
REQ-012 Prescaler shall count 0..PRESC-1 freely from reset and assert an internal tick in the cycle it equals PRESC-1. With PRESC = 1, tick is asserted every cycle.
REQ-013 Write to CTRL with enable=1 on a disabled channel shall load counter with PERIOD on the same edge. The first tick is counted from the next edge onward.
REQ-014 Write to CTRL with enable=1 on an already enabled channel shall update periodic and irq_en only, without reloading the counter.
REQ-015 Write to CTRL with enable=0 shall clear enable and counter on that edge. Pending shall be kept.
REQ-016 Write to PERIOD shall not alter a running counter; the new value is used at the next load or reload.
REQ-017 On a tick with enable=1 and counter > 1, counter shall decrement by 1.
REQ-018 On a tick with enable=1 and counter = 1, the channel fires: pending set. Periodic mode: counter reloads PERIOD. One-shot mode: counter becomes 0 and enable clears.
REQ-019 A channel loaded with PERIOD = 0 shall never fire and shall hold counter at 0 while enabled.
REQ-020 Fire latency: with PRESC = 1 and PERIOD = P, int_out shall rise exactly P edges after the enabling write edge. Periodic firing repeats every P*PRESC cycles.
REQ-021 Pending shall be sticky until int_ack[ch] is high on an edge. If fire and ack occur on the same edge, pending shall remain set.
REQ-022 int_out[ch] shall follow pending AND irq_en with one register stage. Clearing irq_en masks the output without clearing pending.
REQ-023 If a CTRL write and a tick hit the same channel on the same edge, the write shall take priority and the tick is ignored for that channel.
REQ-024 cfg_ch values >= NCH shall be ignored with no state change.
REQ-025 Channels shall be fully independent. Writes and acks to one channel shall never alter another.

Reset
REQ-026 While reset is low, the following shall be 0 asynchronously: prescaler, all counters, PERIOD, enable, periodic, irq_en, pending, and int_out.
REQ-027 Reset asserted mid-count shall abort all channels. After release, no channel fires until re-enabled.

Configuration
REQ-028 Macro TIMER_BANK_READBACK_EN defined: add input rd_ch (width as cfg_ch) and registered outputs rd_count (WIDTH) and rd_pending (NCH), updated every cycle, one-cycle latency, 0 in reset. rd_count returns the counter of channel rd_ch; rd_pending returns all pending bits.
REQ-029 Macro TIMER_BANK_READBACK_EN undefined: those ports and their registers are absent, and all other behaviour is identical.

Verification
REQ-030 PRESC=1, ch0 PERIOD=3, CTRL=0b111 at edge E -> int_out[0] rises after edge E+3, stays high until int_ack[0], then re-asserts after edge E+6.
REQ-031 One-shot: ch1 PERIOD=5, CTRL=0b101 -> single fire at E+5. Enable reads 0 afterwards, with no second fire within 20 cycles.
REQ-032 PRESC=4, ch2 PERIOD=2, periodic -> int_out[2] pulses spaced 8 cycles apart. Ack pulse coinciding with a fire edge leaves pending set.
REQ-033 ch3 PERIOD=0, enable -> no fire in 50 cycles. PERIOD write of 7 while ch0 runs with 3 -> old period completes, then the 7-period takes effect.
REQ-034 Reset pulled low mid-count on 4 active channels -> all outputs 0 immediately. No fire for 30 cycles after release without new writes.
REQ-035 TIMER_BANK_READBACK_EN build: rd_ch=0 during REQ-030 stimulus -> rd_count sequence 3,2,1,3 with one-cycle lag.
